// File: rtl/outstanding_manager_if.sv
// outstanding_manager_if
// Groups every handshake and bus signal of the outstanding manager.
//   cmd_*            : local command port (sequencer -> manager)
//   req_*            : request channel (manager -> fabric)
//   rsp_*            : response strobe (fabric -> manager), no back-pressure
//   cpl_*            : completion port (manager -> sequencer)
//   outstanding_cnt  : number of non-FREE tracker entries
//   err_unexpected_id: one-cycle pulse on a response that matches no entry
// Modport master is the manager side. Modport slave is the surrounding
// sequencer/fabric side.
interface outstanding_manager_if #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [ID_WIDTH-1:0]   req_id;

  logic                  rsp_valid;
  logic [ID_WIDTH-1:0]   rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_resp;

  logic                  cpl_valid;
  logic                  cpl_ready;
  logic                  cpl_write;
  logic [ID_WIDTH-1:0]   cpl_id;
  logic [ADDR_WIDTH-1:0] cpl_addr;
  logic [DATA_WIDTH-1:0] cpl_data;
  logic                  cpl_resp;
  logic                  cpl_timeout;

  logic [CNT_WIDTH-1:0]  outstanding_cnt;
  logic                  err_unexpected_id;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data,
    output cmd_ready,
    output req_valid, req_write, req_addr, req_data, req_id,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_resp,
    output cpl_valid, cpl_write, cpl_id, cpl_addr, cpl_data, cpl_resp, cpl_timeout,
    input  cpl_ready,
    output outstanding_cnt, err_unexpected_id
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_data,
    input  cmd_ready,
    input  req_valid, req_write, req_addr, req_data, req_id,
    output req_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_resp,
    input  cpl_valid, cpl_write, cpl_id, cpl_addr, cpl_data, cpl_resp, cpl_timeout,
    output cpl_ready,
    input  outstanding_cnt, err_unexpected_id
  );
endinterface

// File: rtl/outstanding_manager.sv
// outstanding_manager
// Multi-outstanding bus manager. Commands are tagged with the index of the
// tracker entry they occupy, issued on the request channel, and matched
// against out-of-order responses by ID. One completion is returned per
// command; a command that sees no response within TIMEOUT_CYCLES completes
// with a timeout flag and its slot is parked as ZOMBIE until the late
// response shows up.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : outstanding_manager_if.master (cmd/req/rsp/cpl channels, status)
// The interface parameters must match the module parameters.
module outstanding_manager #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  outstanding_manager_if.master bus
);
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  // The counter is cleared in the allocation cycle, so the entry must leave
  // ISSUED on the edge where it holds TIMEOUT_CYCLES-2 for DONE to be
  // visible exactly TIMEOUT_CYCLES cycles after the command handshake.
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_ISSUED,
    ST_DONE,
    ST_ZOMBIE
  } entry_state_t;

  entry_state_t          state_q [MAX_OUTSTANDING];
  entry_state_t          state_d [MAX_OUTSTANDING];
  logic                  write_q [MAX_OUTSTANDING];
  logic                  write_d [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] addr_q  [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] addr_d  [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0] data_q  [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0] data_d  [MAX_OUTSTANDING];
  logic                  resp_q  [MAX_OUTSTANDING];
  logic                  resp_d  [MAX_OUTSTANDING];
  logic                  tmo_q   [MAX_OUTSTANDING];
  logic                  tmo_d   [MAX_OUTSTANDING];
  logic [TMO_WIDTH-1:0]  ctr_q   [MAX_OUTSTANDING];
  logic [TMO_WIDTH-1:0]  ctr_d   [MAX_OUTSTANDING];

  logic                  req_valid_q, req_valid_d;
  logic                  req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0] req_addr_q,  req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q,  req_data_d;
  logic [ID_WIDTH-1:0]   req_id_q,    req_id_d;
  logic                  err_q,       err_d;

  logic                  free_found;
  logic [ID_WIDTH-1:0]   free_idx;
  logic                  done_found;
  logic [ID_WIDTH-1:0]   done_idx;
  logic                  rsp_known;
  logic [CNT_WIDTH-1:0]  busy_cnt;
  logic                  cpl_write, cpl_resp, cpl_timeout;
  logic [ADDR_WIDTH-1:0] cpl_addr;
  logic [DATA_WIDTH-1:0] cpl_data;
  logic                  cmd_ready, cmd_fire, cpl_fire;

  // Scanning from the top index down lets the lowest matching entry win.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    done_found  = 1'b0;
    done_idx    = '0;
    rsp_known   = 1'b0;
    busy_cnt    = '0;
    cpl_write   = 1'b0;
    cpl_addr    = '0;
    cpl_data    = '0;
    cpl_resp    = 1'b0;
    cpl_timeout = 1'b0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) begin
        free_found = 1'b1;
        free_idx   = ID_WIDTH'(i);
      end else begin
        busy_cnt = busy_cnt + CNT_WIDTH'(1);
      end
      if (state_q[i] == ST_DONE) begin
        done_found  = 1'b1;
        done_idx    = ID_WIDTH'(i);
        cpl_write   = write_q[i];
        cpl_addr    = addr_q[i];
        cpl_data    = data_q[i];
        cpl_resp    = resp_q[i];
        cpl_timeout = tmo_q[i];
      end
      if ((bus.rsp_id == ID_WIDTH'(i)) &&
          ((state_q[i] == ST_ISSUED) || (state_q[i] == ST_ZOMBIE))) begin
        rsp_known = 1'b1;
      end
    end
  end

  // A new command may only be taken when the request register can accept it.
  assign cmd_ready = free_found && (!req_valid_q || bus.req_ready);
  assign cmd_fire  = bus.cmd_valid && cmd_ready;
  assign cpl_fire  = done_found && bus.cpl_ready;

  // Per-entry next state. Allocation, response and completion always target
  // entries in different states, so they never collide on one entry.
  always_comb begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      state_d[i] = state_q[i];
      write_d[i] = write_q[i];
      addr_d[i]  = addr_q[i];
      data_d[i]  = data_q[i];
      resp_d[i]  = resp_q[i];
      tmo_d[i]   = tmo_q[i];
      ctr_d[i]   = ctr_q[i];
      case (state_q[i])
        ST_FREE: begin
          if (cmd_fire && (free_idx == ID_WIDTH'(i))) begin
            state_d[i] = ST_ISSUED;
            write_d[i] = bus.cmd_write;
            addr_d[i]  = bus.cmd_addr;
            data_d[i]  = bus.cmd_data;
            resp_d[i]  = 1'b0;
            tmo_d[i]   = 1'b0;
            ctr_d[i]   = '0;
          end
        end
        ST_ISSUED: begin
          // A response landing on the timeout edge takes priority.
          if (bus.rsp_valid && (bus.rsp_id == ID_WIDTH'(i))) begin
            state_d[i] = ST_DONE;
            resp_d[i]  = bus.rsp_resp;
            if (!write_q[i]) begin
              data_d[i] = bus.rsp_data;
            end
          end else if (ctr_q[i] == TMO_LAST) begin
            state_d[i] = ST_DONE;
            resp_d[i]  = 1'b1;
            tmo_d[i]   = 1'b1;
          end else begin
            ctr_d[i] = ctr_q[i] + TMO_WIDTH'(1);
          end
        end
        ST_DONE: begin
          if (cpl_fire && (done_idx == ID_WIDTH'(i))) begin
            state_d[i] = tmo_q[i] ? ST_ZOMBIE : ST_FREE;
          end
        end
        ST_ZOMBIE: begin
          if (bus.rsp_valid && (bus.rsp_id == ID_WIDTH'(i))) begin
            state_d[i] = ST_FREE;
          end
        end
        default: state_d[i] = ST_FREE;
      endcase
    end
  end

  // Request register; a command accepted in the same cycle as a request
  // handshake refills it directly so back-to-back issue has no bubble.
  always_comb begin
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_id_d    = req_id_q;
    if (cmd_fire) begin
      req_valid_d = 1'b1;
      req_write_d = bus.cmd_write;
      req_addr_d  = bus.cmd_addr;
      req_data_d  = bus.cmd_data;
      req_id_d    = free_idx;
    end else if (bus.req_ready) begin
      req_valid_d = 1'b0;
    end
    err_d = bus.rsp_valid && !rsp_known;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        state_q[i] <= ST_FREE;
        write_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        resp_q[i]  <= 1'b0;
        tmo_q[i]   <= 1'b0;
        ctr_q[i]   <= '0;
      end
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        state_q[i] <= state_d[i];
        write_q[i] <= write_d[i];
        addr_q[i]  <= addr_d[i];
        data_q[i]  <= data_d[i];
        resp_q[i]  <= resp_d[i];
        tmo_q[i]   <= tmo_d[i];
        ctr_q[i]   <= ctr_d[i];
      end
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_id_q    <= req_id_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready         = cmd_ready;
  assign bus.req_valid         = req_valid_q;
  assign bus.req_write         = req_write_q;
  assign bus.req_addr          = req_addr_q;
  assign bus.req_data          = req_data_q;
  assign bus.req_id            = req_id_q;
  assign bus.cpl_valid         = done_found;
  assign bus.cpl_write         = cpl_write;
  assign bus.cpl_id            = done_idx;
  assign bus.cpl_addr          = cpl_addr;
  assign bus.cpl_data          = cpl_data;
  assign bus.cpl_resp          = cpl_resp;
  assign bus.cpl_timeout       = cpl_timeout;
  assign bus.outstanding_cnt   = busy_cnt;
  assign bus.err_unexpected_id = err_q;
endmodule

// File: tb/tb_outstanding_manager.sv
// tb_outstanding_manager
// Directed bench for outstanding_manager with a completion scoreboard.
// Stimulus pushes the completion it expects whenever it issues the response
// (or arranges the timeout) that should produce it; the monitor pops and
// compares on every completion handshake.
module tb_outstanding_manager;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MO = 4;
  localparam int TO = 8;

  typedef struct {
    logic          write;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          resp;
    logic          timeout;
  } cpl_t;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   err_seen  = 0;
  int   err_before;
  cpl_t exp_q[$];
  cpl_t mon_e;

  always #5 clk = ~clk;

  outstanding_manager_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                           .MAX_OUTSTANDING(MO)) bus ();

  outstanding_manager #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                        .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cpl(input logic wr, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic resp, input logic tmo);
    cpl_t e;
    e.write = wr; e.id = id; e.addr = addr; e.data = data; e.resp = resp; e.timeout = tmo;
    exp_q.push_back(e);
  endtask

  // Presents one command and returns just after the edge that accepts it.
  task automatic apply_stimulus(input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data);
    int guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    while (!bus.cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!bus.cmd_ready) begin
      total_cnt++;
      $display("[TB] FAIL cmd_accept: cmd_ready stuck at 0, expected acceptance within 50 cycles");
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [IW-1:0] id, input logic [DW-1:0] data, input logic resp);
    bus.rsp_valid = 1'b1;
    bus.rsp_id    = id;
    bus.rsp_data  = data;
    bus.rsp_resp  = resp;
    tick();
    bus.rsp_valid = 1'b0;
  endtask

  // Completion scoreboard and error-pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus.cpl_valid && bus.cpl_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("[TB] FAIL cpl_unexpected: got completion id %0d, expected none", bus.cpl_id);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("cpl_id",      bus.cpl_id,      mon_e.id);
        check_output("cpl_write",   bus.cpl_write,   mon_e.write);
        check_output("cpl_addr",    bus.cpl_addr,    mon_e.addr);
        check_output("cpl_data",    bus.cpl_data,    mon_e.data);
        check_output("cpl_resp",    bus.cpl_resp,    mon_e.resp);
        check_output("cpl_timeout", bus.cpl_timeout, mon_e.timeout);
      end
    end
    if (bus.err_unexpected_id) err_seen++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.req_ready = 1'b1;
    bus.rsp_valid = 1'b0; bus.rsp_id = '0; bus.rsp_data = '0; bus.rsp_resp = 1'b0;
    bus.cpl_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset values");
    check_output("rst_cmd_ready", bus.cmd_ready, 1);
    check_output("rst_req_valid", bus.req_valid, 0);
    check_output("rst_cpl_valid", bus.cpl_valid, 0);
    check_output("rst_err",       bus.err_unexpected_id, 0);
    check_output("rst_cnt",       bus.outstanding_cnt, 0);
    check_output("rst_req_addr",  bus.req_addr, 0);
    check_output("rst_req_data",  bus.req_data, 0);
    check_output("rst_cpl_data",  bus.cpl_data, 0);

    $display("[TB] ordered write/read");
    apply_stimulus(1'b1, 8'h10, 32'h1111_1111);
    check_output("wr_req_valid", bus.req_valid, 1);
    check_output("wr_req_write", bus.req_write, 1);
    check_output("wr_req_addr",  bus.req_addr, 8'h10);
    check_output("wr_req_data",  bus.req_data, 32'h1111_1111);
    check_output("wr_req_id",    bus.req_id, 0);
    apply_stimulus(1'b0, 8'h10, 32'h0);
    check_output("rd_req_id",    bus.req_id, 1);
    check_output("rd_req_write", bus.req_write, 0);
    expect_cpl(1'b1, 4'd0, 8'h10, 32'h1111_1111, 1'b0, 1'b0);
    send_rsp(4'd0, 32'hDEAD_BEEF, 1'b0);
    expect_cpl(1'b0, 4'd1, 8'h10, 32'h1111_1111, 1'b0, 1'b0);
    send_rsp(4'd1, 32'h1111_1111, 1'b0);
    repeat (3) tick();
    check_output("ord_cnt_idle", bus.outstanding_cnt, 0);

    $display("[TB] fill and out-of-order");
    for (int k = 0; k < MO; k++) apply_stimulus(1'b0, AW'(8'h20 + k), 32'h0);
    check_output("full_cmd_ready", bus.cmd_ready, 0);
    check_output("full_cnt",       bus.outstanding_cnt, 4);
    expect_cpl(1'b0, 4'd3, 8'h23, 32'hA3, 1'b0, 1'b0);
    send_rsp(4'd3, 32'hA3, 1'b0);
    check_output("done_cmd_ready", bus.cmd_ready, 0);
    expect_cpl(1'b0, 4'd1, 8'h21, 32'hA1, 1'b0, 1'b0);
    send_rsp(4'd1, 32'hA1, 1'b0);
    check_output("freed_cmd_ready", bus.cmd_ready, 1);
    expect_cpl(1'b0, 4'd0, 8'h20, 32'hA0, 1'b0, 1'b0);
    send_rsp(4'd0, 32'hA0, 1'b0);
    expect_cpl(1'b0, 4'd2, 8'h22, 32'hA2, 1'b0, 1'b0);
    send_rsp(4'd2, 32'hA2, 1'b0);
    repeat (3) tick();
    check_output("ooo_cnt_idle", bus.outstanding_cnt, 0);

    $display("[TB] request backpressure");
    bus.req_ready = 1'b0;
    apply_stimulus(1'b1, 8'h30, 32'hCAFE_0001);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'h31; bus.cmd_data = 32'hCAFE_0002;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      check_output("bp_req_valid", bus.req_valid, 1);
      check_output("bp_req_addr",  bus.req_addr, 8'h30);
      check_output("bp_req_data",  bus.req_data, 32'hCAFE_0001);
      check_output("bp_req_id",    bus.req_id, 0);
      check_output("bp_cmd_ready", bus.cmd_ready, 0);
    end
    bus.req_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check_output("bp_next_req_id",   bus.req_id, 1);
    check_output("bp_next_req_addr", bus.req_addr, 8'h31);
    expect_cpl(1'b1, 4'd0, 8'h30, 32'hCAFE_0001, 1'b1, 1'b0);
    send_rsp(4'd0, 32'h0, 1'b1);
    expect_cpl(1'b1, 4'd1, 8'h31, 32'hCAFE_0002, 1'b0, 1'b0);
    send_rsp(4'd1, 32'h0, 1'b0);
    repeat (3) tick();

    $display("[TB] timeout and late response");
    apply_stimulus(1'b0, 8'h40, 32'h0);
    expect_cpl(1'b0, 4'd0, 8'h40, 32'h0, 1'b1, 1'b1);
    repeat (TO - 2) tick();
    check_output("tmo_early_cpl_valid", bus.cpl_valid, 0);
    tick();
    check_output("tmo_cpl_valid",   bus.cpl_valid, 1);
    check_output("tmo_cpl_timeout", bus.cpl_timeout, 1);
    check_output("tmo_cpl_resp",    bus.cpl_resp, 1);
    tick();
    check_output("zombie_cnt",       bus.outstanding_cnt, 1);
    check_output("zombie_cpl_valid", bus.cpl_valid, 0);
    err_before = err_seen;
    send_rsp(4'd0, 32'h99, 1'b0);
    check_output("late_cnt", bus.outstanding_cnt, 0);
    tick();
    check_output("late_no_err", err_seen - err_before, 0);

    $display("[TB] response on the timeout edge");
    apply_stimulus(1'b0, 8'h60, 32'h0);
    expect_cpl(1'b0, 4'd0, 8'h60, 32'h55, 1'b0, 1'b0);
    repeat (TO - 2) tick();
    check_output("edge_pre_cpl_valid", bus.cpl_valid, 0);
    send_rsp(4'd0, 32'h55, 1'b0);
    check_output("edge_cpl_valid",   bus.cpl_valid, 1);
    check_output("edge_cpl_timeout", bus.cpl_timeout, 0);
    repeat (2) tick();

    $display("[TB] unexpected responses");
    err_before = err_seen;
    send_rsp(4'd2, 32'h0, 1'b0);
    check_output("unexp_err_pulse", bus.err_unexpected_id, 1);
    tick();
    check_output("unexp_err_clear", bus.err_unexpected_id, 0);
    check_output("unexp_cnt",       bus.outstanding_cnt, 0);
    send_rsp(4'd9, 32'h0, 1'b0);
    check_output("range_err_pulse", bus.err_unexpected_id, 1);
    tick();
    check_output("unexp_err_count", err_seen - err_before, 2);

    $display("[TB] simultaneous alloc, response and completion");
    bus.cpl_ready = 1'b0;
    apply_stimulus(1'b0, 8'h50, 32'h0);
    apply_stimulus(1'b0, 8'h51, 32'h0);
    expect_cpl(1'b0, 4'd1, 8'h51, 32'hB1, 1'b0, 1'b0);
    send_rsp(4'd1, 32'hB1, 1'b0);
    check_output("sim_cpl_valid", bus.cpl_valid, 1);
    check_output("sim_cpl_id",    bus.cpl_id, 1);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'h52; bus.cmd_data = 32'h0000_B2B2;
    bus.rsp_valid = 1'b1; bus.rsp_id = 4'd0; bus.rsp_data = 32'hB0; bus.rsp_resp = 1'b0;
    bus.cpl_ready = 1'b1;
    expect_cpl(1'b0, 4'd0, 8'h50, 32'hB0, 1'b0, 1'b0);
    check_output("sim_cmd_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.rsp_valid = 1'b0;
    check_output("sim_cnt",       bus.outstanding_cnt, 2);
    check_output("sim_req_id",    bus.req_id, 2);
    check_output("sim_req_valid", bus.req_valid, 1);
    check_output("sim_next_cpl",  bus.cpl_id, 0);
    tick();
    expect_cpl(1'b1, 4'd2, 8'h52, 32'h0000_B2B2, 1'b0, 1'b0);
    send_rsp(4'd2, 32'hFFFF, 1'b0);
    repeat (2) tick();
    check_output("sim_cnt_idle", bus.outstanding_cnt, 0);

    $display("[TB] reset mid-flight");
    for (int k = 0; k < 3; k++) apply_stimulus(1'b0, AW'(8'h70 + k), 32'h0);
    check_output("mid_cnt", bus.outstanding_cnt, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mid_rst_cnt",       bus.outstanding_cnt, 0);
    check_output("mid_rst_req_valid", bus.req_valid, 0);
    check_output("mid_rst_cpl_valid", bus.cpl_valid, 0);
    check_output("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check_output("mid_rst_req_addr",  bus.req_addr, 0);
    send_rsp(4'd0, 32'h0, 1'b0);
    check_output("mid_rst_err", bus.err_unexpected_id, 1);
    repeat (3) tick();

    check_output("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/outstanding_manager.md
# outstanding_manager

Synthesizable multi-outstanding bus manager. It accepts read and write commands from a local command port and issues them on the request channel, each tagged with a transaction ID. It tracks up to MAX_OUTSTANDING in-flight transactions and matches out-of-order responses by ID. It returns one completion per command, or a timeout completion when no response arrives in time. It sits between test or sequencer logic and the write/read slave fabric, replacing the behavioural task-based manager.

## Interface
- ADDR_WIDTH, 8, address width
- DATA_WIDTH, 32, data width
- ID_WIDTH, 4, transaction ID width; must satisfy 2**ID_WIDTH >= MAX_OUTSTANDING
- MAX_OUTSTANDING, 4, tracker entries (1..2**ID_WIDTH)
- TIMEOUT_CYCLES, 64, cycles in ISSUED before timeout (>=2)

- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_data  in  DATA_WIDTH  write data (ignored for reads)
- req_valid / req_ready  out / in  1  request handshake to fabric
- req_write, req_addr, req_data, req_id  out  1/ADDR_WIDTH/DATA_WIDTH/ID_WIDTH  request payload
- rsp_valid  in  1  response strobe; always accepted (no ready)
- rsp_id, rsp_data, rsp_resp  in  ID_WIDTH/DATA_WIDTH/1  response payload; rsp_resp 1 = error
- cpl_valid / cpl_ready  out / in  1  completion handshake
- cpl_write, cpl_id, cpl_addr, cpl_data, cpl_resp, cpl_timeout  out  1/ID_WIDTH/ADDR_WIDTH/DATA_WIDTH/1/1  completion payload
- outstanding_cnt  out  $clog2(MAX_OUTSTANDING+1)  number of non-FREE entries
- err_unexpected_id  out  1  one-cycle pulse on a response that matches no entry

## Operation
- **Tracker.** Entry i holds state, write, addr, data, resp and a timeout counter.
  - Entry i's transaction ID is i, zero-extended to ID_WIDTH.
  - Entry states are FREE, ISSUED, DONE and ZOMBIE.
- **Allocation.**
  - cmd_ready = (any entry FREE) && (!req_valid || req_ready).
  - On a cmd handshake, the lowest-index FREE entry moves to ISSUED. Its payload is captured and its counter cleared.
  - The req register loads {cmd_write, cmd_addr, cmd_data, i} and req_valid=1 on the next cycle.
- **Request.** req_* holds stable while req_valid && !req_ready. req_valid drops after the handshake unless a new command loads it in the same cycle.
- **Response, when rsp_valid:**
  - ISSUED entry with matching ID: goes to DONE. Reads capture rsp_data; writes keep cmd data. resp is set to rsp_resp.
  - ZOMBIE entry with matching ID: goes to FREE; the response is dropped with no completion.
  - FREE or DONE entry, or ID >= MAX_OUTSTANDING: dropped; err_unexpected_id=1 next cycle.
- **Timeout.**
  - The counter increments every cycle the entry is ISSUED.
  - When it reaches TIMEOUT_CYCLES, the entry goes to DONE with resp=1 and a timeout flag.
  - On completion of a timed-out entry, the entry goes to ZOMBIE rather than FREE. The slot stays reserved until its late response arrives or rst; slot leak is accepted.
- **Completion.**
  - cpl_* is driven combinationally from the lowest-index DONE entry; cpl_valid = (any DONE).
  - On a cpl handshake, the entry goes to FREE, or to ZOMBIE if it timed out.
  - Completions are in index order, not issue order.
- **Simultaneous events.**
  - Response and timeout on the same entry in the same cycle: the response wins (normal DONE, timeout flag 0).
  - cmd alloc, rsp and cpl in one cycle all act on distinct entries and must all take effect.
  - outstanding_cnt reflects the registered state.

## Timing
- Reset values:
  - All entries FREE; req_valid=0, cpl_valid=0, err_unexpected_id=0, outstanding_cnt=0.
  - cmd_ready=1 from the first cycle after rst deasserts.
  - All payload outputs are 0.
- rst asserted mid-operation clears everything in one cycle. Responses to pre-reset IDs arriving afterwards flag err_unexpected_id.
- Cycle-level latencies:

| Path | From | To | Latency |
|---|---|---|---|
| cmd to request | cmd handshake (cycle N) | req_valid | N+1 |
| response to completion | rsp at cycle N | cpl_valid (if entry lowest DONE) | N+1 |
| response to error pulse | rsp at cycle N | err_unexpected_id | N+1 |
| freed slot to cmd | cpl handshake (cycle M) | slot usable by cmd_ready | M+1 |

- Back-to-back: with req_ready=1, one command per cycle is accepted until full.
- Full (MAX_OUTSTANDING non-FREE entries): cmd_ready=0.
- Timeout: an entry allocated at cycle N with no response reaches DONE at N+TIMEOUT_CYCLES (cpl_timeout=1).

## Test plan
- **Ordered write/read.** Write 0x10←0x11111111, then read 0x10; slave responds in order, resp=0. Expect completions id0 write resp=0, then id1 read data=0x11111111.
- **Fill and out-of-order.** MAX_OUTSTANDING=4; issue 4 reads with rsp withheld.
  - Expect cmd_ready=0 and outstanding_cnt=4.
  - Respond ids 3,1,0,2 with data 0xA3,0xA1,0xA0,0xA2. Expect each cpl_data to match its id.
  - Expect cmd_ready=1 the cycle after the first cpl handshake.
- **Request backpressure.** Hold req_ready=0 for 5 cycles with 2 commands pending. Expect req_* stable and cmd_ready=0 while req_valid && !req_ready.
- **Timeout and late response.**
  - TIMEOUT_CYCLES=8, no response. Expect cpl_valid at alloc+8 with cpl_timeout=1, cpl_resp=1; entry goes to ZOMBIE and outstanding_cnt stays 1.
  - A late rsp for that id then frees the slot, with no completion and no err.
- **Unexpected and simultaneous events.**
  - rsp_id=2 with entry 2 FREE: expect an err_unexpected_id pulse and no state change.
  - Same cycle: cmd alloc, rsp for id0, and cpl handshake for id1. Expect all three effects.
- **Reset mid-flight.** rst with 3 outstanding. Expect all outputs at reset values next cycle; a subsequent rsp id0 flags err_unexpected_id.
